pc_predict_unit: RTL and testbench

PC_PREDICT_UNIT -- requirements
Module: pc_predict_unit

---
 rtl/pc_predict_unit.sv | 164 ++++++++++++++++
 tb/tb_pc_predict_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pc_predict_unit.sv
// Fetch PC generator with a direct-mapped branch history/target table.
// Resolves branches in execute, redirects on mispredict and supports a sticky HALTED state.
module pc_predict_unit #(
  parameter int PC_W      = 16,
  parameter int OFF_W     = 9,
  parameter int BHT_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              halt,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic              ex_branch_reg,
  input  logic [2:0]        ex_cond,
  input  logic [OFF_W-1:0]  ex_imm,
  input  logic [2:0]        ex_flags,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [PC_W-1:0]   ex_rs_data,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_pred_target,
  output logic [PC_W-1:0]   pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  output logic              redirect,
  output logic              halted,
  output logic [15:0]       mispredict_cnt
);

  // state   | meaning
  // S_RUN   | fetching normally
  // S_HALTED| HLT retired at fetch; PC frozen until reset
  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int TAG_W = PC_W - IDX_W - 1;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(2);

  logic [0:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;

  logic             valid_q [BHT_DEPTH];
  logic [TAG_W-1:0] tag_q   [BHT_DEPTH];
  logic [1:0]       ctr_q   [BHT_DEPTH];
  logic [PC_W-1:0]  tgt_q   [BHT_DEPTH];

  logic            flag_z, flag_v, flag_n;
  logic            cond_true;
  logic            is_branch;
  logic            actual_taken;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] br_offset;
  logic [PC_W-1:0] actual_target;
  logic [PC_W-1:0] redirect_pc;

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic [1:0]       wr_ctr;
  logic             tbl_update;

  assign flag_z = ex_flags[2];
  assign flag_v = ex_flags[1];
  assign flag_n = ex_flags[0];

  always_comb begin
    cond_true = 1'b0;
    case (ex_cond)
      3'b000:  cond_true = ~flag_z;
      3'b001:  cond_true = flag_z;
      3'b010:  cond_true = ~flag_z & ~flag_n;
      3'b011:  cond_true = flag_n;
      3'b100:  cond_true = flag_n | (~flag_z & ~flag_n);
      3'b101:  cond_true = flag_n | flag_z;
      3'b110:  cond_true = flag_v;
      default: cond_true = 1'b1;
    endcase
  end

  assign is_branch    = ex_branch | ex_branch_reg;
  assign actual_taken = ex_valid & is_branch & cond_true;
  assign seq_pc       = ex_pc + PC_STEP;
  assign br_offset    = {{(PC_W-OFF_W-1){ex_imm[OFF_W-1]}}, ex_imm, 1'b0};
  assign actual_target = ex_branch_reg ? ex_rs_data : (seq_pc + br_offset);
  assign redirect_pc   = actual_taken ? actual_target : seq_pc;

  // A non-branch predicted taken falls out of the first term since actual_taken is 0.
  assign redirect = ex_valid &
                    ((actual_taken != ex_pred_taken) |
                     (actual_taken & (ex_pred_target != actual_target)));

  assign rd_idx = pc_q[IDX_W:1];
  assign rd_tag = pc_q[PC_W-1:IDX_W+1];

  assign pred_taken  = valid_q[rd_idx] & (tag_q[rd_idx] == rd_tag) & ctr_q[rd_idx][1];
  assign pred_target = pred_taken ? tgt_q[rd_idx] : (pc_q + PC_STEP);

  assign wr_idx     = ex_pc[IDX_W:1];
  assign wr_tag     = ex_pc[PC_W-1:IDX_W+1];
  assign tbl_update = ex_valid & is_branch;

  always_comb begin
    wr_ctr = ctr_q[wr_idx];
    if (actual_taken) begin
      if (ctr_q[wr_idx] != 2'b11) wr_ctr = ctr_q[wr_idx] + 2'd1;
    end else begin
      if (ctr_q[wr_idx] != 2'b00) wr_ctr = ctr_q[wr_idx] - 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_RUN && halt && !stall && !redirect) state_d = S_HALTED;
  end

  always_comb begin
    pc_d = pred_target;
    if (state_q == S_HALTED) pc_d = pc_q;
    else if (redirect)       pc_d = redirect_pc;
    else if (stall)          pc_d = pc_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (redirect && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Written regardless of stall/halt; reads this cycle still see the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
        tgt_q[i]   <= '0;
      end
    end else if (tbl_update) begin
      valid_q[wr_idx] <= 1'b1;
      tag_q[wr_idx]   <= wr_tag;
      ctr_q[wr_idx]   <= wr_ctr;
      if (actual_taken) tgt_q[wr_idx] <= actual_target;
    end
  end

  assign pc             = pc_q;
  assign halted         = (state_q == S_HALTED);
  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit: expected PC/count/halted pushed to a scoreboard
// queue with each step and compared after the following clock edge.
module tb_pc_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, halt;
  logic        ex_valid, ex_branch, ex_branch_reg;
  logic [2:0]  ex_cond, ex_flags;
  logic [8:0]  ex_imm;
  logic [15:0] ex_pc, ex_rs_data, ex_pred_target;
  logic        ex_pred_taken;
  logic [15:0] pc, pred_target, mispredict_cnt;
  logic        pred_taken, redirect, halted;

  int errors = 0;
  int checks = 0;

  typedef struct { string tag; logic [15:0] pc; logic [15:0] cnt; logic halted; } exp_t;
  exp_t sb[$];

  logic [15:0] exp_cnt;

  pc_predict_unit #(.PC_W(16), .OFF_W(9), .BHT_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_branch_reg(ex_branch_reg),
    .ex_cond(ex_cond), .ex_imm(ex_imm), .ex_flags(ex_flags),
    .ex_pc(ex_pc), .ex_rs_data(ex_rs_data),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .redirect(redirect), .halted(halted), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_branch = 0; ex_branch_reg = 0; ex_cond = 0; ex_imm = 0;
    ex_flags = 0; ex_pc = 0; ex_rs_data = 0; ex_pred_taken = 0; ex_pred_target = 0;
  endtask

  task automatic drive_b(input logic [15:0] epc, input logic [2:0] cond, input logic [8:0] imm,
                         input logic [2:0] flags, input logic ptk, input logic [15:0] ptgt);
    clear_ex();
    ex_valid = 1; ex_branch = 1; ex_pc = epc; ex_cond = cond; ex_imm = imm;
    ex_flags = flags; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic step(input string tag, input logic [15:0] epc, input logic [15:0] ecnt,
                      input logic ehalt);
    exp_t e, got;
    e.tag = tag; e.pc = epc; e.cnt = ecnt; e.halted = ehalt;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = sb.pop_front();
    chk({got.tag, ".pc"}, {16'h0, pc}, {16'h0, got.pc});
    chk({got.tag, ".cnt"}, {16'h0, mispredict_cnt}, {16'h0, got.cnt});
    chk({got.tag, ".halted"}, {31'h0, halted}, {31'h0, got.halted});
  endtask

  initial begin
    rst_n = 0; stall = 0; halt = 0; clear_ex();
    exp_cnt = 0;
    #12;
    chk("rst.pc", {16'h0, pc}, 32'h0);
    chk("rst.halted", {31'h0, halted}, 32'h0);
    chk("rst.cnt", {16'h0, mispredict_cnt}, 32'h0);
    chk("rst.pred", {31'h0, pred_taken}, 32'h0);
    @(negedge clk);
    rst_n = 1;

    // Sequential fetch
    for (int i = 1; i <= 3; i++) begin
      step("seq", 16'(2 * i), exp_cnt, 1'b0);
      chk("seq.pred", {31'h0, pred_taken}, 32'h0);
    end

    // B always at 0x10, offset 4 halfwords, predicted not taken
    drive_b(16'h0010, 3'b111, 9'h004, 3'b000, 1'b0, 16'h0000);
    #1 chk("b1.redirect", {31'h0, redirect}, 32'h1);
    exp_cnt++;
    step("b1", 16'h001A, exp_cnt, 1'b0);

    drive_b(16'h0010, 3'b111, 9'h004, 3'b000, 1'b0, 16'h0000);
    #1 chk("b2.redirect", {31'h0, redirect}, 32'h1);
    exp_cnt++;
    step("b2", 16'h001A, exp_cnt, 1'b0);

    // BR back to 0x10 so the trained entry is looked up
    clear_ex();
    ex_valid = 1; ex_branch_reg = 1; ex_cond = 3'b111; ex_pc = 16'h0040; ex_rs_data = 16'h0010;
    #1 chk("br0.redirect", {31'h0, redirect}, 32'h1);
    exp_cnt++;
    step("br0", 16'h0010, exp_cnt, 1'b0);
    chk("lookup.pred_taken", {31'h0, pred_taken}, 32'h1);
    chk("lookup.pred_target", {16'h0, pred_target}, 32'h001A);

    drive_b(16'h0010, 3'b111, 9'h004, 3'b000, 1'b1, 16'h001A);
    #1 chk("b3.redirect", {31'h0, redirect}, 32'h0);
    step("b3", 16'h001A, exp_cnt, 1'b0);

    // BR if Z, wrong predicted target
    clear_ex();
    ex_valid = 1; ex_branch_reg = 1; ex_cond = 3'b001; ex_flags = 3'b100; ex_pc = 16'h0060;
    ex_rs_data = 16'h1234; ex_pred_taken = 1; ex_pred_target = 16'h1230;
    #1 chk("br1.redirect", {31'h0, redirect}, 32'h1);
    exp_cnt++;
    step("br1", 16'h1234, exp_cnt, 1'b0);

    // BNE with Z=1: not taken, predicted not taken
    drive_b(16'h0020, 3'b000, 9'h010, 3'b100, 1'b0, 16'h0000);
    #1 chk("bnt.redirect", {31'h0, redirect}, 32'h0);
    step("bnt", 16'h1236, exp_cnt, 1'b0);

    // Non-branch predicted taken redirects to ex_pc+2
    clear_ex();
    ex_valid = 1; ex_pc = 16'h0050; ex_pred_taken = 1; ex_pred_target = 16'h0300;
    #1 chk("nb.redirect", {31'h0, redirect}, 32'h1);
    exp_cnt++;
    step("nb", 16'h0052, exp_cnt, 1'b0);

    // Stall holds PC and masks halt
    clear_ex();
    stall = 1; halt = 1;
    step("stall", 16'h0052, exp_cnt, 1'b0);
    stall = 0;

    // Halt with a redirect in the same cycle is wrong-path
    drive_b(16'h0080, 3'b111, 9'h004, 3'b000, 1'b0, 16'h0000);
    exp_cnt++;
    step("halt_rd", 16'h008A, exp_cnt, 1'b0);

    // Halt alone: enters HALTED, PC takes its last advance then freezes
    clear_ex();
    step("halt", 16'h008C, exp_cnt, 1'b1);
    halt = 0;
    for (int i = 0; i < 10; i++) begin
      drive_b(16'(16'h0100 + 4 * i), 3'b111, 9'h002, 3'b000, 1'b0, 16'h0000);
      #1 chk("hlt.redirect", {31'h0, redirect}, 32'h1);
      exp_cnt++;
      step("hlt", 16'h008C, exp_cnt, 1'b1);
    end

    // Asynchronous reset mid-redirect
    drive_b(16'h0200, 3'b111, 9'h004, 3'b000, 1'b0, 16'h0000);
    #2 rst_n = 0;
    #1;
    chk("arst.pc", {16'h0, pc}, 32'h0);
    chk("arst.cnt", {16'h0, mispredict_cnt}, 32'h0);
    chk("arst.halted", {31'h0, halted}, 32'h0);
    @(negedge clk);
    clear_ex();
    rst_n = 1;
    exp_cnt = 0;
    step("post_rst", 16'h0002, exp_cnt, 1'b0);
    step("post_rst", 16'h0004, exp_cnt, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
